// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 byte transmitter using request-to-send, driving pull-low enables.
// Optional single retry after NACK or timeout when PS2_HOST_TX_RETRY_EN is defined.
`timescale 1ns/1ps
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 2800,
    parameter int unsigned TIMEOUT_CYCLES = 420000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2clk_in,
    input  logic       ps2data_in,
    output logic       ps2clk_oe,
    output logic       ps2data_oe,
    input  logic [7:0] tx_data,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       error
);
    localparam int unsigned IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned BW = 4;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SHIFT,
        ACK,
        WAIT_IDLE,
        FAIL
`ifdef PS2_HOST_TX_RETRY_EN
        , RETRY
`endif
    } state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   icnt, icnt_nxt;
    logic [TW-1:0]   tcnt, tcnt_nxt;
    logic [BW-1:0]   bcnt, bcnt_nxt;
    logic [7:0]      data_q, data_nxt;
    logic            parity_q, parity_nxt;
    logic            clk_oe_nxt, data_oe_nxt, busy_nxt, done_nxt, error_nxt;
`ifdef PS2_HOST_TX_RETRY_EN
    logic            attempt, attempt_nxt;
`endif

    // Pin synchronizers; lines idle high so the flops reset to 1 to avoid a false edge.
    logic clk_s1, clk_s2, clk_h, data_s1, data_s2;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            clk_h   <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= ps2clk_in;
            clk_s2  <= clk_s1;
            clk_h   <= clk_s2;
            data_s1 <= ps2data_in;
            data_s2 <= data_s1;
        end
    end

    logic fe_c;
    logic timeout_c;
    logic fail_c;
    assign fe_c      = clk_h & ~clk_s2;
    assign timeout_c = (tcnt == TW'(TIMEOUT_CYCLES - 1));

    // Next-state and next-output logic
    always_comb begin
        state_nxt   = state;
        icnt_nxt    = icnt;
        tcnt_nxt    = tcnt;
        bcnt_nxt    = bcnt;
        data_nxt    = data_q;
        parity_nxt  = parity_q;
        clk_oe_nxt  = ps2clk_oe;
        data_oe_nxt = ps2data_oe;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        error_nxt   = 1'b0;
        fail_c      = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
        attempt_nxt = attempt;
`endif

        // Free-running saturating timeout counter, cleared on entry to REQ
        if (tcnt != TW'(TIMEOUT_CYCLES))
            tcnt_nxt = tcnt + TW'(1);

        case (state)
            IDLE: begin
                clk_oe_nxt  = 1'b0;
                data_oe_nxt = 1'b0;
                if (start && !busy) begin
                    data_nxt   = tx_data;
                    parity_nxt = ~^tx_data;
                    busy_nxt   = 1'b1;
                    clk_oe_nxt = 1'b1;
                    icnt_nxt   = '0;
                    state_nxt  = INHIBIT;
`ifdef PS2_HOST_TX_RETRY_EN
                    attempt_nxt = 1'b0;
`endif
                end
            end
            INHIBIT: begin
                icnt_nxt = icnt + IW'(1);
                if (icnt == IW'(INHIBIT_CYCLES - 1)) begin
                    clk_oe_nxt  = 1'b0;
                    data_oe_nxt = 1'b1;
                    tcnt_nxt    = '0;
                    bcnt_nxt    = '0;
                    state_nxt   = REQ;
                end
            end
            REQ: begin
                state_nxt = SHIFT;
                fail_c    = timeout_c;
            end
            SHIFT: begin
                if (fe_c) begin
                    bcnt_nxt = bcnt + BW'(1);
                    if (bcnt < BW'(8)) begin
                        data_oe_nxt = ~data_q[bcnt[2:0]];
                    end else if (bcnt == BW'(8)) begin
                        data_oe_nxt = ~parity_q;
                    end else begin
                        data_oe_nxt = 1'b0;
                        state_nxt   = ACK;
                    end
                end
                fail_c = timeout_c;
            end
            ACK: begin
                if (fe_c) begin
                    if (!data_s2)
                        state_nxt = WAIT_IDLE;
                    else
                        fail_c = 1'b1;
                end
                if (timeout_c)
                    fail_c = 1'b1;
            end
            WAIT_IDLE: begin
                if (clk_s2 && data_s2) begin
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
                fail_c = timeout_c;
            end
            FAIL: begin
                state_nxt = IDLE;
            end
`ifdef PS2_HOST_TX_RETRY_EN
            RETRY: begin
                clk_oe_nxt = 1'b1;
                icnt_nxt   = '0;
                state_nxt  = INHIBIT;
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // NACK or timeout: release both lines, then retry once or report the error
        if (fail_c) begin
            clk_oe_nxt  = 1'b0;
            data_oe_nxt = 1'b0;
            done_nxt    = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
            if (!attempt) begin
                attempt_nxt = 1'b1;
                state_nxt   = RETRY;
            end else begin
                error_nxt = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = FAIL;
            end
`else
            error_nxt = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = FAIL;
`endif
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            icnt       <= '0;
            tcnt       <= '0;
            bcnt       <= '0;
            data_q     <= '0;
            parity_q   <= 1'b0;
            ps2clk_oe  <= 1'b0;
            ps2data_oe <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
            attempt    <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            icnt       <= icnt_nxt;
            tcnt       <= tcnt_nxt;
            bcnt       <= bcnt_nxt;
            data_q     <= data_nxt;
            parity_q   <= parity_nxt;
            ps2clk_oe  <= clk_oe_nxt;
            ps2data_oe <= data_oe_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            error      <= error_nxt;
`ifdef PS2_HOST_TX_RETRY_EN
            attempt    <= attempt_nxt;
`endif
        end
    end

endmodule
